// File: rtl/ce_stage_sequencer.sv
// Purpose : releases NUM_STAGES clock-enable domains one at a time, in order,
//           with DELAY_IN+1 CE-qualified cycles between consecutive releases.
// Latency : first stage released 1+(DELAY_IN+1) edges after reset/restart; CE_OUT is combinational.
// Backpressure: none; CE=0 freezes the schedule, RESTART re-runs it from stage 0.
//
// Ports:
//   CLK       system clock, all state on the rising edge
//   RESET_N   asynchronous active-low reset
//   CE        master clock enable; the schedule only advances on CE=1 edges
//   RESTART   synchronous request to re-run the whole sequence
//   DELAY_IN  inter-stage delay, captured once per sequence in START
//   STAGE_EN  registered per-stage release flags (monotonic within a sequence)
//   CE_OUT    per-stage gated enable: CE & STAGE_EN[k]
//   BUSY      registered, high while stages are still being released
//   READY     registered, high once every stage is released
module ce_stage_sequencer #(
    parameter int NUM_STAGES  = 4,
    parameter int DELAY_WIDTH = 8
) (
    input  logic                   CLK,
    input  logic                   RESET_N,
    input  logic                   CE,
    input  logic                   RESTART,
    input  logic [DELAY_WIDTH-1:0] DELAY_IN,
    output logic [NUM_STAGES-1:0]  STAGE_EN,
    output logic [NUM_STAGES-1:0]  CE_OUT,
    output logic                   BUSY,
    output logic                   READY
);

    localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);

    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                 state_q;
    logic [DELAY_WIDTH-1:0] dly_q;
    logic [DELAY_WIDTH-1:0] cnt_q;
    logic [IDX_W-1:0]       idx_q;
    logic [NUM_STAGES-1:0]  stage_bit;

    // One-hot mask of the stage that is released next; OR-ing it in keeps
    // already released bits set.
    assign stage_bit = NUM_STAGES'(1) << idx_q;

    // Zero latency from CE: downstream stages see the master enable the same
    // cycle once they have been released.
    assign CE_OUT = STAGE_EN & {NUM_STAGES{CE}};

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= ST_START;
            dly_q    <= '0;
            cnt_q    <= '0;
            idx_q    <= '0;
            STAGE_EN <= '0;
            BUSY     <= 1'b0;
            READY    <= 1'b0;
        end else if (RESTART) begin
            // Restart wins over a release that would happen on this same edge.
            state_q  <= ST_START;
            STAGE_EN <= '0;
            BUSY     <= 1'b0;
            READY    <= 1'b0;
        end else begin
            case (state_q)
                ST_START: begin
                    // Leaves START regardless of CE; the delay is frozen here
                    // for the whole sequence.
                    dly_q   <= DELAY_IN;
                    cnt_q   <= DELAY_IN;
                    idx_q   <= '0;
                    state_q <= ST_WAIT;
                    BUSY    <= 1'b1;
                    READY   <= 1'b0;
                end
                ST_WAIT: begin
                    if (CE) begin
                        if (cnt_q != '0) begin
                            cnt_q <= cnt_q - DELAY_WIDTH'(1);
                        end else begin
                            STAGE_EN <= STAGE_EN | stage_bit;
                            if (idx_q == LAST_IDX) begin
                                state_q <= ST_DONE;
                                BUSY    <= 1'b0;
                                READY   <= 1'b1;
                            end else begin
                                idx_q <= idx_q + IDX_W'(1);
                                cnt_q <= dly_q;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    // All stages released; hold until reset or restart.
                end
                default: begin
                    state_q <= ST_START;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ce_stage_sequencer.sv
module tb_ce_stage_sequencer;

    localparam int N = 4;
    localparam int W = 8;

    logic         CLK = 1'b0;
    logic         RESET_N;
    logic         CE;
    logic         RESTART;
    logic [W-1:0] DELAY_IN;
    logic [N-1:0] STAGE_EN;
    logic [N-1:0] CE_OUT;
    logic         BUSY;
    logic         READY;

    logic         CE1;
    logic         RESTART1;
    logic [W-1:0] DELAY_IN1;
    logic [0:0]   STAGE_EN1;
    logic [0:0]   CE_OUT1;
    logic         BUSY1;
    logic         READY1;

    int checks = 0;
    int errors = 0;

    // Reference model state: CE value seen at each edge of the current
    // sequence (element 0 is edge 1, the START edge) and the captured delay.
    bit ce_hist[$];
    int edge_n;
    int model_d;

    always #5 CLK = ~CLK;

    ce_stage_sequencer #(.NUM_STAGES(N), .DELAY_WIDTH(W)) dut (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .CE       (CE),
        .RESTART  (RESTART),
        .DELAY_IN (DELAY_IN),
        .STAGE_EN (STAGE_EN),
        .CE_OUT   (CE_OUT),
        .BUSY     (BUSY),
        .READY    (READY)
    );

    ce_stage_sequencer #(.NUM_STAGES(1), .DELAY_WIDTH(W)) dut1 (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .CE       (CE1),
        .RESTART  (RESTART1),
        .DELAY_IN (DELAY_IN1),
        .STAGE_EN (STAGE_EN1),
        .CE_OUT   (CE_OUT1),
        .BUSY     (BUSY1),
        .READY    (READY1)
    );

    // Number of stages released so far: after the START edge, every
    // (D+1)-th CE-qualified edge releases the next stage.
    function automatic int released();
        int r = 0;
        int c = 0;
        for (int i = 1; i < ce_hist.size(); i++) begin
            if (r == N) break;
            if (ce_hist[i]) c++;
            if (c == model_d + 1) begin
                r++;
                c = 0;
            end
        end
        return r;
    endfunction

    // Expected {STAGE_EN, BUSY, READY} after the current edge.
    function automatic logic [N+1:0] expect_vec();
        int r = released();
        logic [N-1:0] se = '0;
        for (int k = 0; k < r; k++) se[k] = 1'b1;
        return {se, (edge_n >= 1 && r < N), (r == N)};
    endfunction

    // Called between edges: drive inputs, advance one edge, sample 1 time unit later.
    task automatic step(input bit ce_v, input bit rst_v);
        CE      = ce_v;
        RESTART = rst_v;
        @(posedge CLK);
        if (rst_v) begin
            ce_hist.delete();
            edge_n = 0;
        end else begin
            ce_hist.push_back(ce_v);
            edge_n++;
        end
        #1;
    endtask

    task automatic test_reset();
        RESET_N   = 1'b0;
        CE        = 1'b1;
        RESTART   = 1'b0;
        DELAY_IN  = 8'd3;
        CE1       = 1'b1;
        RESTART1  = 1'b0;
        DELAY_IN1 = 8'd255;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({STAGE_EN, CE_OUT, BUSY, READY} !== '0) begin
                errors++;
                $display("FAIL reset cycle %0d: got %b required 0", i, {STAGE_EN, CE_OUT, BUSY, READY});
            end
            @(posedge CLK);
            #1;
        end
        ce_hist.delete();
        edge_n  = 0;
        model_d = 3;
        RESET_N = 1'b1;
    endtask

    task automatic test_nominal();
        logic [N+1:0] exp;
        for (int e = 1; e <= 20; e++) begin
            step(1'b1, 1'b0);
            exp = expect_vec();
            checks++;
            if ({STAGE_EN, BUSY, READY} !== exp) begin
                errors++;
                $display("FAIL nominal edge %0d: got %b required %b", edge_n, {STAGE_EN, BUSY, READY}, exp);
            end
            checks++;
            if (CE_OUT !== (exp[N+1:2] & {N{CE}})) begin
                errors++;
                $display("FAIL nominal_ce_out edge %0d: got %b required %b", edge_n, CE_OUT, exp[N+1:2]);
            end
        end
        checks++;
        if (STAGE_EN !== 4'b1111 || READY !== 1'b1 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL nominal_final: got en=%b rdy=%b busy=%b required 1111/1/0", STAGE_EN, READY, BUSY);
        end
    endtask

    task automatic test_ce_gaps();
        logic [N+1:0] exp;
        bit cv;
        DELAY_IN = 8'd3;
        model_d  = 3;
        step(1'b1, 1'b1);
        for (int e = 1; e <= 22; e++) begin
            cv = !(e == 3 || e == 4);
            step(cv, 1'b0);
            exp = expect_vec();
            checks++;
            if ({STAGE_EN, BUSY, READY} !== exp) begin
                errors++;
                $display("FAIL ce_gaps edge %0d: got %b required %b", edge_n, {STAGE_EN, BUSY, READY}, exp);
            end
            checks++;
            if (CE_OUT !== (exp[N+1:2] & {N{cv}})) begin
                errors++;
                $display("FAIL ce_gaps_ce_out edge %0d: got %b required %b", edge_n, CE_OUT, exp[N+1:2] & {N{cv}});
            end
            if (e == 6 || e == 7) begin
                checks++;
                if (STAGE_EN[0] !== (e == 7)) begin
                    errors++;
                    $display("FAIL ce_gaps_stage0 edge %0d: got %b required %b", e, STAGE_EN[0], e == 7);
                end
            end
        end
        // CE_OUT must follow CE with no clock edge in between.
        CE = 1'b0;
        #1;
        checks++;
        if (CE_OUT !== 4'b0000) begin
            errors++;
            $display("FAIL ce_out_zero_latency: got %b required 0000", CE_OUT);
        end
    endtask

    task automatic test_zero_delay();
        logic [N+1:0] exp;
        DELAY_IN = 8'd0;
        model_d  = 0;
        step(1'b1, 1'b1);
        for (int e = 1; e <= 8; e++) begin
            if (e == 3) DELAY_IN = 8'd7;
            step(1'b1, 1'b0);
            exp = expect_vec();
            checks++;
            if ({STAGE_EN, BUSY, READY} !== exp) begin
                errors++;
                $display("FAIL zero_delay edge %0d: got %b required %b", edge_n, {STAGE_EN, BUSY, READY}, exp);
            end
        end
    endtask

    task automatic test_restart();
        logic [N+1:0] exp;
        DELAY_IN = 8'd3;
        model_d  = 3;
        step(1'b1, 1'b1);
        for (int e = 1; e <= 30; e++) begin
            step(1'b1, e == 9);
            exp = expect_vec();
            checks++;
            if ({STAGE_EN, BUSY, READY} !== exp) begin
                errors++;
                $display("FAIL restart edge %0d: got %b required %b", e, {STAGE_EN, BUSY, READY}, exp);
            end
        end
        // Held restart keeps everything low.
        for (int e = 0; e < 3; e++) begin
            step(1'b1, 1'b1);
            checks++;
            if ({STAGE_EN, CE_OUT, BUSY, READY} !== '0) begin
                errors++;
                $display("FAIL restart_held cycle %0d: got %b required 0", e, {STAGE_EN, CE_OUT, BUSY, READY});
            end
        end
        for (int e = 1; e <= 6; e++) begin
            step(1'b1, 1'b0);
            exp = expect_vec();
            checks++;
            if ({STAGE_EN, BUSY, READY} !== exp) begin
                errors++;
                $display("FAIL restart_release edge %0d: got %b required %b", edge_n, {STAGE_EN, BUSY, READY}, exp);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [N+1:0] exp;
        #2;
        CE      = 1'b1;
        RESET_N = 1'b0;
        #1;
        checks++;
        if ({STAGE_EN, CE_OUT, BUSY, READY} !== '0) begin
            errors++;
            $display("FAIL async_reset: got %b required 0", {STAGE_EN, CE_OUT, BUSY, READY});
        end
        #1;
        RESET_N = 1'b1;
        ce_hist.delete();
        edge_n  = 0;
        model_d = 3;
        DELAY_IN = 8'd3;
        for (int e = 1; e <= 18; e++) begin
            step(1'b1, 1'b0);
            exp = expect_vec();
            checks++;
            if ({STAGE_EN, BUSY, READY} !== exp) begin
                errors++;
                $display("FAIL async_rerun edge %0d: got %b required %b", edge_n, {STAGE_EN, BUSY, READY}, exp);
            end
        end
    endtask

    task automatic test_random();
        logic [N+1:0] exp;
        for (int it = 0; it < 6; it++) begin
            model_d  = int'($urandom_range(0, 5));
            DELAY_IN = W'(model_d);
            step(1'b1, 1'b1);
            for (int e = 1; e <= 60; e++) begin
                if (e > 1 && $urandom_range(0, 3) == 0) DELAY_IN = W'($urandom);
                step($urandom_range(0, 99) < 70, 1'b0);
                exp = expect_vec();
                checks++;
                if ({STAGE_EN, BUSY, READY} !== exp) begin
                    errors++;
                    $display("FAIL random it %0d edge %0d: got %b required %b", it, edge_n, {STAGE_EN, BUSY, READY}, exp);
                end
                checks++;
                if (CE_OUT !== (exp[N+1:2] & {N{CE}})) begin
                    errors++;
                    $display("FAIL random_ce_out it %0d edge %0d: got %b required %b", it, edge_n, CE_OUT, exp[N+1:2] & {N{CE}});
                end
            end
        end
    endtask

    task automatic test_single_stage_max();
        DELAY_IN1 = 8'd255;
        CE1       = 1'b1;
        RESTART1  = 1'b1;
        @(posedge CLK);
        #1;
        RESTART1 = 1'b0;
        for (int e = 1; e <= 262; e++) begin
            @(posedge CLK);
            #1;
            if (e == 1 || e == 256) begin
                checks++;
                if ({STAGE_EN1, BUSY1, READY1} !== 3'b010) begin
                    errors++;
                    $display("FAIL single_wait edge %0d: got %b required 010", e, {STAGE_EN1, BUSY1, READY1});
                end
            end
            if (e == 257 || e == 262) begin
                checks++;
                if ({STAGE_EN1, CE_OUT1, BUSY1, READY1} !== 4'b1101) begin
                    errors++;
                    $display("FAIL single_done edge %0d: got %b required 1101", e, {STAGE_EN1, CE_OUT1, BUSY1, READY1});
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_ce_gaps();
        test_zero_delay();
        test_restart();
        test_async_reset();
        test_random();
        test_single_stage_max();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
